block_accumulator: RTL and testbench
====================================

Name: block_accumulator

Overview:
- Parametrised per-lane accumulator for the systolic matrix-block multiplier datapath.
- Sits between the systolic array output and the result writeback.
- Sums NUM_BLOCKS partial-product vectors of LANES lanes and emits one result vector.
- Uses valid/ready handshakes on both sides, a synchronous clear, and back-to-back block streaming with no bubble.

Parameters:
- LANES, 16, number of independent accumulation lanes.
- DATA_W, 16, width of each input lane (unsigned).
- ACC_W, 16, width of each accumulator/output lane; must be >= DATA_W.
- NUM_BLOCKS, 16, input beats summed per result; range 1..255.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous discard of the partial sum in progress.
- in_valid  in  1  in_data holds a partial-product vector.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  LANES*DATA_W  lane 0 in MSBs [LANES*DATA_W-1 -: DATA_W], lane i at the next lower slice.
- out_valid  out  1  out_data holds a completed sum.
- out_ready  in  1  downstream takes out_data this cycle.
- out_data  out  LANES*ACC_W  lane 0 in MSBs, same packing as in_data.
- beat_count  out  8  beats accepted into the current sum (0..NUM_BLOCKS-1).
- overflow  out  1  sticky; set when any lane wraps (or saturates) in the current sum.

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high on `reset`.
- Reset values:
  - out_valid=0, out_data=0, beat_count=0, overflow=0.
  - All accumulators 0; state ACCUM.
  - in_ready=1 in the first cycle after reset.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = !out_valid | out_ready (combinational).
- State ACCUM (out_valid=0):
  - On in_fire, each lane acc[i] <= acc[i] + zero-extend(in lane i), modulo 2^ACC_W.
  - Also beat_count <= beat_count+1.
  - On the in_fire where beat_count==NUM_BLOCKS-1:
    - out_data <= updated sums (latency 1 cycle from the last beat);
    - out_valid <= 1; accumulators <= 0; beat_count <= 0; go to HOLD.
- State HOLD (out_valid=1):
  - out_data and overflow are stable until out_fire.
  - On out_fire without in_fire: out_valid <= 0, overflow <= 0, go to ACCUM.
  - On out_fire with in_fire in the same cycle: accumulators load the in_data lanes directly; beat_count <= 1; overflow is re-evaluated for that beat only; go to ACCUM.
  - If NUM_BLOCKS==1, that beat instead reloads out_data and out_valid stays 1.
- No-handshake cycles:
  - in_valid=0 in ACCUM: hold state; no timeout.
  - out_ready=0 in HOLD: in_ready=0, input is back-pressured, nothing is lost.
- clear:
  - Zeroes the accumulators and beat_count, and clears overflow for the in-progress sum.
  - A beat presented in the same cycle is dropped, even if in_ready=1.
  - Does not affect a result already in HOLD; out_valid and out_data are kept.
- Precedence: reset > clear > in_fire.
- Reset mid-block: partial sum discarded; no out_valid is produced for it.
- overflow: set when any lane's true sum exceeds 2^ACC_W-1 during the current sum; travels with out_data.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: each lane clamps at 2^ACC_W-1 instead of wrapping; overflow is still set on clamp.
- Undefined: modulo-2^ACC_W wrap, as above.

Test Plan:
- Sum and latency: NUM_BLOCKS=4; send 4 beats with all lanes = 16'h0001, out_ready=1 → out_valid rises 1 cycle after the 4th beat; every lane = 16'h0004; overflow=0.
- Lane packing: send ramp data, lane i = i+1, 16 times → lane i out = 16*(i+1); lane 0 in bits [255:240] = 16'h0010, lane 15 = 16'h0100.
- Back-pressure and streaming:
  - hold out_ready=0 for 5 cycles after a result → in_ready=0, out_data stable;
  - then assert out_ready with in_valid → next sum starts with beat_count=1, no bubble cycle.
- Overflow:
  - lane 3 gets 16'hFFFF twice → without ACC_SATURATE_EN, lane 3 = 16'hFFFE and overflow=1;
  - with ACC_SATURATE_EN, lane 3 = 16'hFFFF and overflow=1.
- Clear and reset:
  - accept 2 beats of 16'h0005, assert clear with in_valid → that beat is dropped;
  - 4 more beats of 16'h0001 → output all lanes = 16'h0004;
  - reset asserted mid-block → all outputs 0, no spurious out_valid.
- NUM_BLOCKS=1: continuous in_valid, out_ready=1 → one result per cycle, out_data equals in_data delayed by 1 cycle.

Source files
------------

// File: rtl/block_accumulator.sv
// block_accumulator
//   Per-lane accumulator between the systolic array output and result
//   writeback. Sums NUM_BLOCKS partial-product vectors of LANES lanes and
//   presents one result vector with valid/ready handshakes on both sides.
//   Lane 0 sits in the MSBs of both in_data and out_data.
//   Optional feature: define ACC_SATURATE_EN to clamp each lane at
//   2^ACC_W-1 instead of wrapping modulo 2^ACC_W. Overflow is flagged in
//   both modes.
module block_accumulator #(
  parameter int LANES      = 16,
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 16,
  parameter int NUM_BLOCKS = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*ACC_W-1:0]   out_data,
  output logic [7:0]               beat_count,
  output logic                     overflow
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(NUM_BLOCKS - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q    [LANES];
  logic [ACC_W-1:0] acc_d    [LANES];
  logic [ACC_W-1:0] res_q    [LANES];
  logic [ACC_W-1:0] res_d    [LANES];
  logic [ACC_W-1:0] in_lane  [LANES];
  logic [ACC_W-1:0] lane_sum [LANES];
  logic [ACC_W:0]   sum_wide [LANES];
  logic [LANES-1:0] lane_carry;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             in_fire, out_fire, last_beat;

  // Unpack input lanes (zero-extended) and pack result lanes, lane 0 in MSBs.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign in_lane[i] = ACC_W'(in_data[(LANES-i)*DATA_W-1 -: DATA_W]);
    assign out_data[(LANES-i)*ACC_W-1 -: ACC_W] = res_q[i];
  end

  assign out_valid  = (state_q == HOLD);
  assign in_ready   = !out_valid | out_ready;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign last_beat  = (count_q == LAST_IDX);
  assign beat_count = count_q;
  assign overflow   = ovf_q;

  // Per-lane add with carry-out; the carry marks a wrap (or a clamp).
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum_wide[i]   = {1'b0, acc_q[i]} + {1'b0, in_lane[i]};
      lane_carry[i] = sum_wide[i][ACC_W];
`ifdef ACC_SATURATE_EN
      lane_sum[i]   = sum_wide[i][ACC_W] ? {ACC_W{1'b1}} : sum_wide[i][ACC_W-1:0];
`else
      lane_sum[i]   = sum_wide[i][ACC_W-1:0];
`endif
    end
  end

  // Next-state and datapath update: clear beats in_fire, HOLD waits for out_fire.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = res_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (clear) begin
          acc_d   = '{default: '0};
          count_d = 8'd0;
          ovf_d   = 1'b0;
        end else if (in_fire) begin
          ovf_d = ovf_q | (|lane_carry);
          if (last_beat) begin
            res_d   = lane_sum;
            acc_d   = '{default: '0};
            count_d = 8'd0;
            state_d = HOLD;
          end else begin
            acc_d   = lane_sum;
            count_d = count_q + 8'd1;
          end
        end
      end
      HOLD: begin
        // Accumulators are already zero here; a clear only discards a new beat.
        if (out_fire) begin
          // A single beat cannot overflow because ACC_W >= DATA_W.
          ovf_d = 1'b0;
          if (in_fire && !clear) begin
            if (NUM_BLOCKS == 1) begin
              res_d = in_lane;
            end else begin
              acc_d   = in_lane;
              count_d = 8'd1;
              state_d = ACCUM;
            end
          end else begin
            state_d = ACCUM;
          end
        end
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACCUM;
      count_q <= 8'd0;
      ovf_q   <= 1'b0;
      // NOTE: the lane arrays are reset on purpose: a fresh sum must start at zero and out_data must read zero after reset.
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_block_accumulator.sv
// tb_block_accumulator
//   Three instances (NUM_BLOCKS = 4, 16, 1; 16 lanes of 16 bits) driven by
//   directed scenarios and then random traffic. A sum-level reference model
//   (integer partial sums, beat counts, pending result) is compared against
//   every output on every falling edge; directed scenarios add constant checks.
module tb_block_accumulator;

`ifdef ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid   [3];
  logic         clear_s    [3];
  logic         out_ready  [3];
  logic [255:0] in_data    [3];
  logic         in_ready   [3];
  logic         out_valid  [3];
  logic [255:0] out_data   [3];
  logic [7:0]   beat_count [3];
  logic         overflow   [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    block_accumulator #(
      .LANES(16), .DATA_W(16), .ACC_W(16),
      .NUM_BLOCKS((g == 0) ? 4 : ((g == 1) ? 16 : 1))
    ) dut (
      .clock(clock), .reset(reset), .clear(clear_s[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
      .beat_count(beat_count[g]), .overflow(overflow[g])
    );
  end

  function automatic int nb_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 16 : 1);
  endfunction

  function automatic logic [255:0] splat(input logic [15:0] v);
    return {16{v}};
  endfunction

  function automatic logic [15:0] lane_of(input logic [255:0] v, input int i);
    return v[(16-i)*16-1 -: 16];
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_acc [3][16];
  int unsigned m_res [3][16];
  int          m_cnt [3];
  bit          m_vld [3];
  bit          m_povf[3];
  bit          m_rovf[3];

  always @(posedge clock) begin
    int unsigned s;
    bit rdy, give, take;
    for (int k = 0; k < 3; k++) begin
      rdy  = !m_vld[k] || out_ready[k];
      give = m_vld[k] && out_ready[k];
      take = in_valid[k] && rdy && !clear_s[k];
      if (reset) begin
        for (int i = 0; i < 16; i++) begin m_acc[k][i] = 0; m_res[k][i] = 0; end
        m_cnt[k] = 0; m_vld[k] = 0; m_povf[k] = 0; m_rovf[k] = 0;
      end else begin
        if (give) m_vld[k] = 0;
        if (clear_s[k]) begin
          for (int i = 0; i < 16; i++) m_acc[k][i] = 0;
          m_cnt[k] = 0; m_povf[k] = 0;
        end else if (take) begin
          for (int i = 0; i < 16; i++) begin
            s = m_acc[k][i] + int'(lane_of(in_data[k], i));
            if (s > 65535) begin
              m_povf[k] = 1;
              s = SAT ? 65535 : s - 65536;
            end
            m_acc[k][i] = s;
          end
          m_cnt[k]++;
          if (m_cnt[k] == nb_of(k)) begin
            for (int i = 0; i < 16; i++) begin m_res[k][i] = m_acc[k][i]; m_acc[k][i] = 0; end
            m_rovf[k] = m_povf[k]; m_vld[k] = 1; m_cnt[k] = 0; m_povf[k] = 0;
          end
        end
      end
    end
  end

  // Compare every output of every instance against the model each cycle.
  always @(negedge clock) begin
    logic [255:0] exp_d;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) exp_d[(16-i)*16-1 -: 16] = 16'(m_res[k][i]);
      check($sformatf("u%0d out_valid", k), out_valid[k], m_vld[k]);
      check($sformatf("u%0d in_ready", k), in_ready[k], (!m_vld[k] || out_ready[k]));
      check($sformatf("u%0d beat_count", k), beat_count[k], 8'(m_cnt[k]));
      check($sformatf("u%0d overflow", k), overflow[k], m_vld[k] ? m_rovf[k] : m_povf[k]);
      check($sformatf("u%0d out_data", k), out_data[k], exp_d);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; clear_s[k] = 1'b0; out_ready[k] = 1'b1; in_data[k] = '0;
    end
  endtask

  initial begin
    logic [255:0] v;
    logic [15:0]  w;
    idle();
    step(); step();
    reset = 1'b0;

    // Reset values.
    check("rst out_valid", out_valid[0], 1'b0);
    check("rst in_ready", in_ready[0], 1'b1);
    check("rst out_data", out_data[0], '0);
    check("rst beat_count", beat_count[0], 8'd0);
    check("rst overflow", overflow[0], 1'b0);

    // Sum and latency, NUM_BLOCKS=4.
    in_valid[0] = 1'b1; in_data[0] = splat(16'h0001);
    for (int n = 1; n <= 3; n++) begin
      step();
      check("lat no_valid_yet", out_valid[0], 1'b0);
      check("lat beat_count", beat_count[0], 8'(n));
    end
    step();
    check("lat out_valid", out_valid[0], 1'b1);
    check("lat out_data", out_data[0], splat(16'h0004));
    check("lat overflow", overflow[0], 1'b0);
    in_valid[0] = 1'b0;
    step();
    check("lat consumed", out_valid[0], 1'b0);

    // Lane packing, NUM_BLOCKS=16 ramp.
    for (int i = 0; i < 16; i++) v[(16-i)*16-1 -: 16] = 16'(i + 1);
    in_valid[1] = 1'b1; in_data[1] = v;
    repeat (16) step();
    check("ramp out_valid", out_valid[1], 1'b1);
    check("ramp lane0", lane_of(out_data[1], 0), 16'h0010);
    check("ramp lane15", lane_of(out_data[1], 15), 16'h0100);
    for (int i = 0; i < 16; i++) v[(16-i)*16-1 -: 16] = 16'(16 * (i + 1));
    check("ramp all", out_data[1], v);
    in_valid[1] = 1'b0;
    step();

    // Back-pressure then bubble-free streaming.
    out_ready[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = splat(16'h0002);
    repeat (4) step();
    check("bp out_valid", out_valid[0], 1'b1);
    in_data[0] = splat(16'h0007);
    repeat (5) begin
      step();
      check("bp in_ready", in_ready[0], 1'b0);
      check("bp out_data", out_data[0], splat(16'h0008));
    end
    out_ready[0] = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      step();
      check("stream out_valid", out_valid[0], 1'b0);
      check("stream beat_count", beat_count[0], 8'(n));
    end
    step();
    check("stream result", out_data[0], splat(16'h001C));
    check("stream out_valid", out_valid[0], 1'b1);
    in_valid[0] = 1'b0;
    step();

    // Overflow on lane 3.
    v = '0; v[(16-3)*16-1 -: 16] = 16'hFFFF;
    in_valid[0] = 1'b1; in_data[0] = v;
    step(); step();
    check("ovf partial", overflow[0], 1'b1);
    in_data[0] = '0;
    step(); step();
    check("ovf lane3", lane_of(out_data[0], 3), SAT ? 16'hFFFF : 16'hFFFE);
    check("ovf lane0", lane_of(out_data[0], 0), 16'h0000);
    check("ovf flag", overflow[0], 1'b1);
    in_valid[0] = 1'b0;
    step();
    check("ovf cleared", overflow[0], 1'b0);

    // Clear drops the concurrent beat.
    in_valid[0] = 1'b1; in_data[0] = splat(16'h0005);
    step(); step();
    check("clr before", beat_count[0], 8'd2);
    clear_s[0] = 1'b1;
    step();
    check("clr beat_count", beat_count[0], 8'd0);
    clear_s[0] = 1'b0; in_data[0] = splat(16'h0001);
    repeat (4) step();
    check("clr result", out_data[0], splat(16'h0004));
    in_valid[0] = 1'b0;
    step();

    // Reset mid-block.
    in_valid[0] = 1'b1; in_data[0] = splat(16'h0009);
    step(); step();
    in_valid[0] = 1'b0; reset = 1'b1;
    step();
    check("mid_rst out_data", out_data[0], '0);
    check("mid_rst beat_count", beat_count[0], 8'd0);
    reset = 1'b0;
    repeat (3) begin
      step();
      check("mid_rst no_valid", out_valid[0], 1'b0);
    end

    // NUM_BLOCKS=1 pass-through, one result per cycle.
    in_valid[2] = 1'b1;
    repeat (10) begin
      for (int i = 0; i < 16; i++) begin
        w = 16'($urandom);
        v[(16-i)*16-1 -: 16] = w;
      end
      in_data[2] = v;
      step();
      check("nb1 out_valid", out_valid[2], 1'b1);
      check("nb1 out_data", out_data[2], v);
    end
    in_valid[2] = 1'b0;
    step();

    // Random traffic on all instances against the model.
    repeat (3000) begin
      for (int k = 0; k < 3; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        out_ready[k] = ($urandom_range(0, 3) != 0);
        clear_s[k]   = ($urandom_range(0, 40) == 0);
        for (int i = 0; i < 16; i++) begin
          w = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hF000, 16'hFFFF))
                                          : 16'($urandom_range(0, 16'h0FFF));
          v[(16-i)*16-1 -: 16] = w;
        end
        in_data[k] = v;
      end
      reset = ($urandom_range(0, 500) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
